// File: rtl/rng_collect_ctrl.sv
// Collects ring-oscillator bits into words: edge-detects done, discards a warm-up
// run after each enable, packs MSB-first, hands words off valid/ready, and latches a repetition fault.
module rng_collect_ctrl #(
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned WARMUP    = 64,
  parameter int unsigned REP_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              en,
  input  logic              rnd_bit,
  input  logic              done,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              fault,
  input  logic              fault_clr
);

  localparam int unsigned WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int unsigned RUN_W  = $clog2(REP_LIMIT + 1);
  localparam int unsigned BIT_W  = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t              state, state_n;
  logic                done_q;
  logic                accept;
  logic                last_bit, last_bit_n;
  logic [RUN_W-1:0]    run_cnt, run_cnt_n, run_next;
  logic [WARM_W-1:0]   warm_cnt, warm_cnt_n, warm_inc;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
  logic [WORD_W-1:0]   sh, sh_n, sh_shift;
  logic [WORD_W-1:0]   word_n;
  logic                word_valid_n;
  logic                trip;

  assign accept = done & ~done_q;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= S_IDLE;
      done_q     <= 1'b0;
      last_bit   <= 1'b0;
      run_cnt    <= '0;
      warm_cnt   <= '0;
      bit_cnt    <= '0;
      sh         <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      done_q     <= done;
      last_bit   <= last_bit_n;
      run_cnt    <= run_cnt_n;
      warm_cnt   <= warm_cnt_n;
      bit_cnt    <= bit_cnt_n;
      sh         <= sh_n;
      word       <= word_n;
      word_valid <= word_valid_n;
      busy       <= (state_n != S_IDLE);
      fault      <= (state_n == S_FAULT);
    end
  end

  // Next-state, health test and word assembly
  always_comb begin
    state_n      = state;
    last_bit_n   = last_bit;
    run_cnt_n    = run_cnt;
    warm_cnt_n   = warm_cnt;
    bit_cnt_n    = bit_cnt;
    sh_n         = sh;
    word_n       = word;
    word_valid_n = word_valid;
    run_next     = run_cnt;
    warm_inc     = warm_cnt + WARM_W'(1);
    sh_shift     = {sh[WORD_W-2:0], rnd_bit};

    // run_cnt of zero marks the first accept since leaving IDLE
    if (accept) begin
      if ((run_cnt == '0) || (rnd_bit != last_bit)) begin
        run_next = RUN_W'(1);
      end else if (run_cnt != RUN_W'(REP_LIMIT)) begin
        run_next = run_cnt + RUN_W'(1);
      end
    end
    trip = accept && (run_next == RUN_W'(REP_LIMIT));

    case (state)
      S_IDLE: begin
        run_cnt_n  = '0;
        warm_cnt_n = '0;
        bit_cnt_n  = '0;
        sh_n       = '0;
        if (en) begin
          state_n = (WARMUP == 0) ? S_COLLECT : S_WARMUP;
        end
      end

      S_WARMUP, S_COLLECT, S_HOLD: begin
        if (accept) begin
          run_cnt_n  = run_next;
          last_bit_n = rnd_bit;
        end
        if (trip) begin
          state_n      = S_FAULT;
          word_valid_n = 1'b0;
        end else if (state == S_HOLD) begin
          // Word survives en=0 here; leave only after it is taken
          if (word_valid && word_ready) begin
            word_valid_n = 1'b0;
            bit_cnt_n    = '0;
            state_n      = en ? S_COLLECT : S_IDLE;
          end
        end else if (!en) begin
          state_n = S_IDLE;
        end else if (accept) begin
          if (state == S_WARMUP) begin
            warm_cnt_n = warm_inc;
            if (warm_inc == WARM_W'(WARMUP)) begin
              state_n = S_COLLECT;
            end
          end else begin
            sh_n      = sh_shift;
            bit_cnt_n = bit_cnt + BIT_W'(1);
            if (bit_cnt == BIT_W'(WORD_W - 1)) begin
              word_n       = sh_shift;
              word_valid_n = 1'b1;
              bit_cnt_n    = '0;
              state_n      = S_HOLD;
            end
          end
        end
      end

      S_FAULT: begin
        word_valid_n = 1'b0;
        if (fault_clr) begin
          state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule
